// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link blocks (receive deserializer and
// transmit-side wrapper).
//   rx_state_t    : receive FSM state encoding (IDLE, RECV)
//   DEFAULT_WIDTH : default word length in bits
package serdes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_deserializer_rx_out_buffer.sv
// One-entry output holding register with a valid/ready handshake.
// A completed word is loaded when the buffer is empty or is being consumed in
// the same cycle. Otherwise the word is dropped and the sticky overrun flag
// is raised.
// Ports:
//   clk, clr        : clock, asynchronous active-low reset
//   load, word      : a completed word is offered this cycle
//   ready           : consumer takes data this cycle (only counts while valid=1)
//   ovr_clr         : synchronous clear of overrun (a simultaneous set wins)
//   data, valid     : buffered word and its occupancy flag
//   overrun         : sticky flag, a word was dropped
module rx_out_buffer
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic consume;
  logic accept;
  logic drop;

  assign consume = valid & ready;
  // A slot frees up in the same cycle it is read, so there is no bubble
  // between back-to-back words.
  assign accept  = load & (~valid | consume);
  assign drop    = load & valid & ~ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (accept) begin
      data  <= word;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver. It samples a framed bitstream, assembles
// WIDTH-bit words in a shift register and hands each completed word to a
// one-entry valid/ready output buffer. The next frame can arrive while the
// previous word is still waiting to be read.
// Ports:
//   clk, clr                  : clock, asynchronous active-low reset
//   sin, sin_valid, sin_start : serial bit, its qualifier, first-bit marker
//   pout, pout_valid          : received word and buffer-occupied flag
//   pout_ready                : consumer accepts pout this cycle
//   busy                      : a frame is in progress
//   overrun                   : sticky, a completed word was dropped
//   frame_err                 : one-cycle pulse when a frame restarts early
//   ovr_clr                   : synchronous clear of overrun
module serial_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_t        state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             frame_err_reg, frame_err_next;
  logic             load;

  // fresh   : the register as it looks after the first bit of a new frame
  //           (any partial word is discarded)
  // shifted : the register with the current bit appended
  logic [WIDTH-1:0] fresh;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) begin
      fresh   = {{(WIDTH-1){1'b0}}, sin};
      shifted = {shift_reg[WIDTH-2:0], sin};
    end else begin
      fresh   = {sin, {(WIDTH-1){1'b0}}};
      shifted = {sin, shift_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    count_next     = count_reg;
    frame_err_next = 1'b0;
    load           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sin_valid && sin_start) begin
          shift_next = fresh;
          count_next = CW'(1);
          state_next = RECV;
        end
      end
      RECV: begin
        if (sin_valid) begin
          if (sin_start) begin
            // The frame is restarted early: the current bit is bit 1 of
            // the new frame.
            shift_next     = fresh;
            count_next     = CW'(1);
            frame_err_next = 1'b1;
          end else begin
            shift_next = shifted;
            if (count_reg == CW'(WIDTH - 1)) begin
              // This is the final bit. The word offered to the buffer
              // includes it.
              load       = 1'b1;
              count_next = '0;
              state_next = IDLE;
            end else begin
              count_next = count_reg + CW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  rx_out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buffer (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .word    (shifted),
    .ready   (pout_ready),
    .ovr_clr (ovr_clr),
    .data    (pout),
    .valid   (pout_valid),
    .overrun (overrun)
  );

  assign busy      = (state_reg == RECV);
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer. Two instances share the stimulus:
// u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0). Stream bit order in the
// stimulus is bits[7] first.
module tb_serial_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, sin, sin_valid, sin_start, pout_ready, ovr_clr;
  logic [W-1:0] pout_m, pout_l;
  logic pv_m, pv_l, busy_m, busy_l, ovr_m, ovr_l, fe_m, fe_l;

  int n_vec = 0;
  int n_bad = 0;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready), .busy(busy_m),
    .overrun(ovr_m), .frame_err(fe_m), .ovr_clr(ovr_clr)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready), .busy(busy_l),
    .overrun(ovr_l), .frame_err(fe_l), .ovr_clr(ovr_clr)
  );

  typedef struct {
    logic [7:0] bits;
    bit         gaps;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of serial input, then sample 1 time unit after the edge.
  task automatic tick(input logic s, input logic v, input logic st);
    @(negedge clk);
    sin       = s;
    sin_valid = v;
    sin_start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      tick(b[7-i], 1'b1, (i == 0));
      if (i < 7) begin
        check("busy_mid", {31'b0, busy_m}, 32'd1);
        if (gaps) begin
          tick(1'b0, 1'b0, 1'b0);
          check("busy_gap_m", {31'b0, busy_m}, 32'd1);
          check("busy_gap_l", {31'b0, busy_l}, 32'd1);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 8'hA5};
    tbl[1] = '{8'hC0, 1'b0, 8'hC0, 8'h03};
    tbl[2] = '{8'hE1, 1'b0, 8'hE1, 8'h87};
    tbl[3] = '{8'h68, 1'b0, 8'h68, 8'h16};
    tbl[4] = '{8'hA5, 1'b1, 8'hA5, 8'hA5};

    clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0;
    pout_ready = 1'b1; ovr_clr = 1'b0;
    #1;
    check("rst_pout_m", {24'b0, pout_m}, 32'h0);
    check("rst_pv_m", {31'b0, pv_m}, 32'd0);
    check("rst_busy_m", {31'b0, busy_m}, 32'd0);
    check("rst_ovr_m", {31'b0, ovr_m}, 32'd0);
    check("rst_fe_m", {31'b0, fe_m}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;

    // Bits without a start marker are ignored in IDLE.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("idle_ignore_busy", {31'b0, busy_m}, 32'd0);
    check("idle_ignore_pv", {31'b0, pv_m}, 32'd0);

    // Table: single frames with the consumer always ready.
    for (int k = 0; k < 5; k++) begin
      pout_ready = 1'b1;
      send_frame(tbl[k].bits, tbl[k].gaps);
      check($sformatf("v%0d_pv_m", k), {31'b0, pv_m}, 32'd1);
      check($sformatf("v%0d_pout_m", k), {24'b0, pout_m}, {24'b0, tbl[k].exp_m});
      check($sformatf("v%0d_pv_l", k), {31'b0, pv_l}, 32'd1);
      check($sformatf("v%0d_pout_l", k), {24'b0, pout_l}, {24'b0, tbl[k].exp_l});
      check($sformatf("v%0d_busy", k), {31'b0, busy_m}, 32'd0);
      check($sformatf("v%0d_fe", k), {31'b0, fe_m}, 32'd0);
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_consumed", k), {31'b0, pv_m}, 32'd0);
    end

    // Overrun: the second word is dropped, and ovr_clr clears the flag.
    pout_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    check("ovr_first_pv", {31'b0, pv_m}, 32'd1);
    check("ovr_first_pout", {24'b0, pout_m}, 32'h3C);
    check("ovr_pre_flag", {31'b0, ovr_m}, 32'd0);
    send_frame(8'hC3, 1'b0);
    check("ovr_set_m", {31'b0, ovr_m}, 32'd1);
    check("ovr_set_l", {31'b0, ovr_l}, 32'd1);
    check("ovr_keep_m", {24'b0, pout_m}, 32'h3C);
    check("ovr_keep_l", {24'b0, pout_l}, 32'h3C);
    ovr_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'b0, ovr_m}, 32'd0);
    check("ovr_hold_pv", {31'b0, pv_m}, 32'd1);
    check("ovr_hold_pout", {24'b0, pout_m}, 32'h3C);
    tick(1'b0, 1'b0, 1'b0);
    check("ovr_still_held", {24'b0, pout_m}, 32'h3C);
    pout_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("ovr_read_out", {31'b0, pv_m}, 32'd0);

    // Completion in the same cycle the held word is consumed: no drop, no bubble.
    pout_ready = 1'b0;
    send_frame(8'hE1, 1'b0);
    check("same_first", {24'b0, pout_m}, 32'hE1);
    b = 8'h68;
    for (int i = 0; i < 7; i++) tick(b[7-i], 1'b1, (i == 0));
    pout_ready = 1'b1;
    tick(b[0], 1'b1, 1'b0);
    check("same_pv", {31'b0, pv_m}, 32'd1);
    check("same_pout_m", {24'b0, pout_m}, 32'h68);
    check("same_pout_l", {24'b0, pout_l}, 32'h16);
    check("same_no_ovr", {31'b0, ovr_m}, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    check("same_consumed", {31'b0, pv_m}, 32'd0);

    // Set and clear of overrun in the same cycle: set wins.
    pout_ready = 1'b0;
    send_frame(8'h81, 1'b0);
    b = 8'hA5;
    for (int i = 0; i < 7; i++) tick(b[7-i], 1'b1, (i == 0));
    ovr_clr = 1'b1;
    tick(b[0], 1'b1, 1'b0);
    ovr_clr = 1'b0;
    check("setwins_ovr", {31'b0, ovr_m}, 32'd1);
    check("setwins_pout", {24'b0, pout_m}, 32'h81);
    ovr_clr = 1'b1;
    pout_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    check("setwins_clr", {31'b0, ovr_m}, 32'd0);
    check("setwins_read", {31'b0, pv_m}, 32'd0);

    // Restart on bit 5: one frame_err pulse, and the partial word is discarded.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, (i == 0));
    b = 8'h96;
    tick(b[7], 1'b1, 1'b1);
    check("restart_fe_m", {31'b0, fe_m}, 32'd1);
    check("restart_fe_l", {31'b0, fe_l}, 32'd1);
    check("restart_busy", {31'b0, busy_m}, 32'd1);
    tick(b[6], 1'b1, 1'b0);
    check("restart_fe_once", {31'b0, fe_m}, 32'd0);
    for (int i = 2; i < 7; i++) tick(b[7-i], 1'b1, 1'b0);
    check("restart_no_partial", {31'b0, pv_m}, 32'd0);
    tick(b[0], 1'b1, 1'b0);
    check("restart_pv", {31'b0, pv_m}, 32'd1);
    check("restart_pout_m", {24'b0, pout_m}, 32'h96);
    check("restart_pout_l", {24'b0, pout_l}, 32'h69);
    tick(1'b0, 1'b0, 1'b0);

    // Reset mid-frame while the buffer holds a word.
    pout_ready = 1'b0;
    send_frame(8'hA5, 1'b0);
    check("pre_rst_pv", {31'b0, pv_m}, 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, (i == 0));
    @(negedge clk);
    clr = 1'b0;
    sin_valid = 1'b0;
    sin_start = 1'b0;
    #1;
    check("midrst_pout_m", {24'b0, pout_m}, 32'h0);
    check("midrst_pout_l", {24'b0, pout_l}, 32'h0);
    check("midrst_pv", {31'b0, pv_m}, 32'd0);
    check("midrst_busy", {31'b0, busy_m}, 32'd0);
    check("midrst_busy_l", {31'b0, busy_l}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    pout_ready = 1'b1;
    send_frame(8'h81, 1'b0);
    check("postrst_pv", {31'b0, pv_m}, 32'd1);
    check("postrst_pout_m", {24'b0, pout_m}, 32'h81);
    check("postrst_pout_l", {24'b0, pout_l}, 32'h81);
    check("postrst_pv_l", {31'b0, pv_l}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
Serial-to-parallel receiver that is the far end of the team's universal shift register used as a parallel-to-serial transmitter. It samples a framed serial bitstream, assembles WIDTH-bit words in a shift register and hands each completed word to a one-entry output buffer with a valid/ready handshake. Because of this double buffering, the next frame can arrive while the previous word is still waiting to be read.

Parameters:
WIDTH, 8, word length in bits; legal range 2 to 32.
MSB_FIRST, 1, bit order. 1 means the first serial bit lands in pout[WIDTH-1] (matches shift-left transmit). 0 means the first bit lands in pout[0] (matches shift-right transmit).

Ports:
clk  input  1  single clock, rising edge.
clr  input  1  asynchronous, active-low reset. Asserts immediately when clr=0; released synchronously to clk.
sin  input  1  serial data bit.
sin_valid  input  1  qualifies sin for the current cycle.
sin_start  input  1  marks the first bit of a frame; only meaningful when sin_valid=1.
pout  output  WIDTH  received word, stable while pout_valid=1.
pout_valid  output  1  output buffer holds an unread word.
pout_ready  input  1  consumer accepts pout this cycle.
busy  output  1  a frame is in progress (state RECV).
overrun  output  1  sticky; a completed word was dropped.
frame_err  output  1  one-cycle pulse; a frame was restarted before it completed.
ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (clr=0), asynchronous and at any time, including mid-frame:
  - Outputs: pout=0, pout_valid=0, busy=0, overrun=0, frame_err=0.
  - Internal: shift register=0, bit counter=0, state=IDLE.
  - A partial frame is discarded.
- FSM state IDLE:
  - sin_valid=1 and sin_start=1: capture the bit, set count=1, go to RECV.
  - sin_valid=1 and sin_start=0: ignore the bit.
- FSM state RECV:
  - Each cycle with sin_valid=1 shifts in one bit and increments count.
  - Bit entry: MSB_FIRST=1 shifts left with sin entering at bit 0. MSB_FIRST=0 shifts right with sin entering at bit WIDTH-1.
  - sin_valid=0 stalls; count and data are held.
- Frame completion:
  - The cycle that accepts bit WIDTH attempts to transfer the assembled word (including that bit) to the output buffer.
  - State returns to IDLE and count returns to 0.
  - Latency: pout_valid=1 in the cycle after the final bit is sampled.
- Back-to-back frames: sin_start with sin_valid in the cycle right after completion begins a new frame with no gap.
- Restart mid-frame (RECV, count between 1 and WIDTH-1, sin_valid=1 and sin_start=1):
  - Discard the partial word.
  - The current bit becomes bit 1 of a new frame and count=1.
  - frame_err pulses for exactly one cycle.
- Output handshake:
  - A word is consumed on a cycle where pout_valid=1 and pout_ready=1.
  - pout and pout_valid hold until consumed; pout_ready has no effect while pout_valid=0.
- Completion versus buffer state:
  - Buffer empty, or consumed in the same cycle: the new word loads and pout_valid stays or becomes 1 with no bubble.
  - Buffer full and not consumed: the new word is dropped, the buffer keeps the old word, and overrun is set.
- overrun:
  - Cleared by ovr_clr=1.
  - If a set and ovr_clr happen in the same cycle, set wins.
- Counter width is $clog2(WIDTH+1). Count never exceeds WIDTH.

Decomposition:
- Shared package serdes_pkg holds the state enumeration (IDLE, RECV) and a default-width constant. The same package is reused by the transmit-side wrapper.
- One natural sub-module: rx_out_buffer, the one-entry valid/ready holding register with load, consume and overrun detection. The shift, count and FSM logic stay in the top module.

Test Plan:
- WIDTH=8, MSB_FIRST=1, pout_ready=1. Send 1,0,1,0,0,1,0,1 with start on bit 1 -> pout=8'hA5, pout_valid=1 for one cycle, one cycle after bit 8.
- MSB_FIRST=0, same bit sequence -> pout=8'hA5 reversed = 8'hA5. Then send 1,1,0,0,0,0,0,0 -> pout=8'h03.
- pout_ready=0. Send frame 8'h3C, then frame 8'hC3 -> pout stays 8'h3C and overrun=1. Pulse ovr_clr -> overrun=0, and pout is still 8'h3C until pout_ready=1.
- Assert sin_start on bit 5 of a frame, then send 7 more bits -> one frame_err pulse. pout equals the 8 bits from the restart onward, and the discarded partial word never appears.
- Insert sin_valid=0 gaps between bits -> result identical to the gapless case; busy=1 across the gaps.
- Drive clr=0 after bit 4, release it, then send a full frame 8'h81 -> outputs are zero during reset, and the post-reset pout is 8'h81 with no residue from the earlier partial frame.
